// File: rtl/kronos_types.sv
// Shared register map, FSM state type and byte-lane merge helper for the
// Kronos machine timer.
package kronos_types;

  localparam logic [4:0] MTIMER_MTIME_LO    = 5'h00;
  localparam logic [4:0] MTIMER_MTIME_HI    = 5'h04;
  localparam logic [4:0] MTIMER_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] MTIMER_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] MTIMER_PRESCALE    = 5'h10;
  localparam logic [4:0] MTIMER_SNAP        = 5'h14;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } mtimer_state_e;

  function automatic logic [31:0] mask_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_v[8*b +: 8];
      else         res[8*b +: 8] = old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/kronos_counter64.sv
// 64-bit up-counter with tick enable and byte-masked word loads; a load to
// either word suppresses the tick for the whole 64 bits in that cycle.
module kronos_counter64
  import kronos_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        ld_lo,
  input  logic        ld_hi,
  input  logic [31:0] ld_data,
  input  logic [3:0]  ld_mask,
  output logic [63:0] value
);

  logic [63:0] value_q;
  logic [63:0] value_d;

  // next count: load overrides tick
  always_comb begin
    value_d = value_q;
    if (ld_lo || ld_hi) begin
      if (ld_lo) value_d[31:0]  = mask_merge(value_q[31:0], ld_data, ld_mask);
      else       value_d[31:0]  = value_q[31:0];
      if (ld_hi) value_d[63:32] = mask_merge(value_q[63:32], ld_data, ld_mask);
      else       value_d[63:32] = value_q[63:32];
    end else if (tick) begin
      value_d = value_q + 64'd1;
    end else begin
      value_d = value_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) value_q <= 64'd0;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/kronos_mtimer.sv
// Memory-mapped RISC-V style machine timer: prescaled 64-bit mtime,
// mtimecmp compare interrupt and a one-cycle-latency data-bus slave.
module kronos_mtimer
  import kronos_types::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_wr_mask,
  input  logic        data_rd_req,
  input  logic        data_wr_req,
  output logic        data_gnt,
  output logic [31:0] data_rd_data,
  output logic        timer_irq
);

  mtimer_state_e state_q, state_d;
  logic        gnt_q, gnt_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [63:0] cmp_q, cmp_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [31:0] snap_q, snap_d;
  logic        irq_q, irq_d;

  logic        hit_s, accept_s, wr_go_s, rd_go_s, tick_s;
  logic [4:0]  offset_s;
  logic [31:0] rd_mux_s, presc_merge_s;
  logic [63:0] mtime_s;
  logic        unused_bits_s;

  assign offset_s = {data_addr[4:2], 2'b00};
  assign hit_s    = (data_rd_req || data_wr_req) && (data_addr[31:5] == BASE_ADDR[31:5]);
  assign accept_s = (state_q == ST_IDLE) && hit_s;
  assign wr_go_s  = accept_s && data_wr_req;
  assign rd_go_s  = accept_s && !data_wr_req;
  assign tick_s   = (pcnt_q == presc_q);
  assign presc_merge_s = mask_merge({16'h0000, presc_q}, data_wr_data, data_wr_mask);
  assign unused_bits_s = ^{data_addr[1:0], presc_merge_s[31:16]};

  kronos_counter64 u_mtime (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick_s),
    .ld_lo   (wr_go_s && (offset_s == MTIMER_MTIME_LO)),
    .ld_hi   (wr_go_s && (offset_s == MTIMER_MTIME_HI)),
    .ld_data (data_wr_data),
    .ld_mask (data_wr_mask),
    .value   (mtime_s)
  );

  // read data selection by word offset
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (offset_s)
      MTIMER_MTIME_LO:    rd_mux_s = mtime_s[31:0];
      MTIMER_MTIME_HI:    rd_mux_s = mtime_s[63:32];
      MTIMER_MTIMECMP_LO: rd_mux_s = cmp_q[31:0];
      MTIMER_MTIMECMP_HI: rd_mux_s = cmp_q[63:32];
      MTIMER_PRESCALE:    rd_mux_s = {16'h0000, presc_q};
      MTIMER_SNAP:        rd_mux_s = snap_q;
      default:            rd_mux_s = 32'h0000_0000;
    endcase
  end

  // bus FSM, register writes, prescaler and interrupt next-state
  always_comb begin
    state_d   = state_q;
    gnt_d     = 1'b0;
    rd_data_d = rd_data_q;
    case (state_q)
      ST_IDLE: begin
        if (hit_s) begin
          state_d   = ST_RESP;
          gnt_d     = 1'b1;
          rd_data_d = data_wr_req ? 32'h0000_0000 : rd_mux_s;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    cmp_d = cmp_q;
    if (wr_go_s && (offset_s == MTIMER_MTIMECMP_LO))
      cmp_d[31:0] = mask_merge(cmp_q[31:0], data_wr_data, data_wr_mask);
    else if (wr_go_s && (offset_s == MTIMER_MTIMECMP_HI))
      cmp_d[63:32] = mask_merge(cmp_q[63:32], data_wr_data, data_wr_mask);
    else
      cmp_d = cmp_q;

    // any PRESCALE write restarts the divider, even with an empty mask
    if (wr_go_s && (offset_s == MTIMER_PRESCALE)) begin
      presc_d = presc_merge_s[15:0];
      pcnt_d  = 16'd0;
    end else begin
      presc_d = presc_q;
      pcnt_d  = tick_s ? 16'd0 : pcnt_q + 16'd1;
    end

    if (rd_go_s && (offset_s == MTIMER_MTIME_LO)) snap_d = mtime_s[63:32];
    else                                           snap_d = snap_q;

    irq_d = (mtime_s >= cmp_q);
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
      rd_data_q <= 32'h0000_0000;
      cmp_q     <= 64'hFFFF_FFFF_FFFF_FFFF;
      presc_q   <= 16'h0000;
      pcnt_q    <= 16'h0000;
      snap_q    <= 32'h0000_0000;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rd_data_q <= rd_data_d;
      cmp_q     <= cmp_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      snap_q    <= snap_d;
      irq_q     <= irq_d;
    end
  end

  assign data_gnt     = gnt_q;
  assign data_rd_data = rd_data_q;
  assign timer_irq    = irq_q;

endmodule

// File: tb/tb_kronos_mtimer.sv
// Directed self-checking bench for kronos_mtimer: reset, carry/snapshot,
// prescale, interrupt, masking/priority, decode and reset-during-response.
module tb_kronos_mtimer;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        rst;
  logic [31:0] data_addr;
  logic [31:0] data_wr_data;
  logic [3:0]  data_wr_mask;
  logic        data_rd_req;
  logic        data_wr_req;
  logic        data_gnt;
  logic [31:0] data_rd_data;
  logic        timer_irq;

  int n_tests = 0;
  int n_fail  = 0;

  kronos_mtimer #(.BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_addr    (data_addr),
    .data_wr_data (data_wr_data),
    .data_wr_mask (data_wr_mask),
    .data_rd_req  (data_rd_req),
    .data_wr_req  (data_wr_req),
    .data_gnt     (data_gnt),
    .data_rd_data (data_rd_data),
    .timer_irq    (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one bus transaction; checks that the grant comes exactly one cycle later
  task automatic bus_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        input string tag, output logic [31:0] rdata);
    int lat;
    lat = 0;
    data_addr = addr; data_wr_data = wdata; data_wr_mask = mask;
    data_rd_req = rd; data_wr_req = wr;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!data_gnt && lat < 8);
    chk({tag, " latency"}, 32'(lat), 32'd1);
    rdata = data_rd_data;
    data_rd_req = 1'b0; data_wr_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] m, input string tag);
    logic [31:0] dummy;
    bus_op(1'b0, 1'b1, BASE + off, d, m, tag, dummy);
  endtask

  task automatic rd(input logic [31:0] off, input string tag, output logic [31:0] d);
    bus_op(1'b1, 1'b0, BASE + off, 32'h0, 4'h0, tag, d);
  endtask

  logic [31:0] v, a, b;
  int gcount, lat;

  initial begin
    rst = 1'b1; data_addr = 32'h0; data_wr_data = 32'h0; data_wr_mask = 4'h0;
    data_rd_req = 1'b0; data_wr_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset gnt", {31'b0, data_gnt}, 32'd0);
    chk("reset rd_data", data_rd_data, 32'h0);
    chk("reset irq", {31'b0, timer_irq}, 32'd0);
    rst = 1'b0;

    rd(32'h08, "rd cmp_lo", v); chk("reset cmp_lo", v, 32'hFFFF_FFFF);
    rd(32'h0C, "rd cmp_hi", v); chk("reset cmp_hi", v, 32'hFFFF_FFFF);
    chk("idle irq", {31'b0, timer_irq}, 32'd0);

    // carry across bit 31 with PRESCALE=0
    wr(32'h04, 32'h0000_0005, 4'hF, "wr mtime_hi");
    wr(32'h00, 32'hFFFF_FFFE, 4'hF, "wr mtime_lo");
    rd(32'h00, "rd mtime_lo", v); chk("carry lo", v, 32'hFFFF_FFFF);
    rd(32'h14, "rd snap", v);     chk("carry snap", v, 32'h0000_0005);
    rd(32'h04, "rd mtime_hi", v); chk("carry hi", v, 32'h0000_0006);

    // prescale 3: 25 ticks in 100 cycles
    wr(32'h10, 32'h0000_0003, 4'hF, "wr prescale");
    rd(32'h00, "rd lo a", a);
    repeat (98) @(posedge clk);
    #1;
    rd(32'h00, "rd lo b", b);
    chk("prescale delta", b - a, 32'd25);

    // interrupt
    wr(32'h10, 32'h0000_0000, 4'hF, "wr prescale0");
    wr(32'h04, 32'h0000_0000, 4'hF, "wr hi0");
    wr(32'h00, 32'h0000_0000, 4'hF, "wr lo0");
    wr(32'h08, 32'h0000_0040, 4'hF, "wr cmp_lo");
    wr(32'h0C, 32'h0000_0000, 4'hF, "wr cmp_hi");
    wr(32'h00, 32'h0000_003C, 4'hF, "wr lo3c");
    chk("irq at 3c", {31'b0, timer_irq}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("irq at 3f", {31'b0, timer_irq}, 32'd0);
    @(posedge clk); #1;
    chk("irq at 40", {31'b0, timer_irq}, 32'd1);
    wr(32'h08, 32'h0000_1000, 4'hF, "wr cmp 1000");
    chk("irq drop", {31'b0, timer_irq}, 32'd0);

    // byte masking, priority, empty mask, reserved, prescale width
    wr(32'h08, 32'hFFFF_FFFF, 4'hF, "wr cmp ones");
    wr(32'h08, 32'hAABB_CCDD, 4'b0101, "wr cmp masked");
    rd(32'h08, "rd cmp masked", v); chk("mask merge", v, 32'hFFBB_FFDD);
    bus_op(1'b1, 1'b1, BASE + 32'h0C, 32'h1234_5678, 4'hF, "rd+wr", v);
    chk("priority rd_data", v, 32'h0);
    rd(32'h0C, "rd cmp_hi2", v); chk("priority write", v, 32'h1234_5678);
    wr(32'h0C, 32'hDEAD_BEEF, 4'h0, "wr mask0");
    rd(32'h0C, "rd cmp_hi3", v); chk("mask0 no change", v, 32'h1234_5678);
    wr(32'h18, 32'hFFFF_FFFF, 4'hF, "wr reserved");
    rd(32'h18, "rd reserved", v); chk("reserved zero", v, 32'h0);
    wr(32'h10, 32'hFFFF_0007, 4'hF, "wr prescale7");
    rd(32'h10, "rd prescale", v); chk("prescale 16b", v, 32'h0000_0007);

    // decode miss
    data_addr = BASE + 32'h40; data_rd_req = 1'b1;
    gcount = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (data_gnt) gcount++;
    end
    data_rd_req = 1'b0;
    chk("decode miss grants", 32'(gcount), 32'd0);
    @(posedge clk); #1;

    // reset during the response cycle of an MTIME_LO write
    data_addr = BASE; data_wr_data = 32'h5555_0000; data_wr_mask = 4'hF; data_wr_req = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!data_gnt && lat < 8);
    chk("rst-wr latency", 32'(lat), 32'd1);
    rst = 1'b1; data_wr_req = 1'b0;
    @(posedge clk); #1;
    chk("rst gnt", {31'b0, data_gnt}, 32'd0);
    rst = 1'b0;
    rd(32'h00, "rd lo rst", v); chk("mtime after rst", v, 32'h0);
    rd(32'h0C, "rd cmp rst", v); chk("cmp after rst", v, 32'hFFFF_FFFF);
    rd(32'h10, "rd presc rst", v); chk("prescale after rst", v, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
